lsu_mem_access: RTL

//  Memory-side consumer of the decode bundle: executes the loads and stores flagged by MemR/MemW.
//  - Accepts one access per instruction from the execute stage.
//  - Drives a single-outstanding, request/grant data-bus port.
//  - Extracts and extends load data.
//  - Stalls the pipeline until the access completes.
//  - Sits between EX and WB: load data feeds the RESULT_MEM leg of the writeback mux.

---
 rtl/lsu_mem_access_pkg.sv | 48 ++++
 rtl/lsu_mem_access_load_align.sv | 29 ++
 rtl/lsu_mem_access.sv | 131 +++++++++++++
 3 files changed

// File: rtl/lsu_mem_access_pkg.sv
// Shared types and the access-legality helper for the load/store unit.
package lsu_mem_access_pkg;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_type_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_type_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  // An access that may not reach the bus: misaligned half/word, or an undefined funct3.
  function automatic logic access_fault(input logic we, input logic [2:0] f3,
                                        input logic [1:0] off);
    logic bad;
    bad = 1'b1;
    if (we) begin
      case (f3)
        3'b000:  bad = 1'b0;
        3'b001:  bad = off[0];
        3'b010:  bad = |off;
        default: bad = 1'b1;
      endcase
    end else begin
      case (f3)
        3'b000, 3'b100: bad = 1'b0;
        3'b001, 3'b101: bad = off[0];
        3'b010:         bad = |off;
        default:        bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

endpackage

// File: rtl/lsu_mem_access_load_align.sv
// Load data extraction: picks the addressed byte/half out of the bus word and extends it.
module lsu_mem_access_load_align
  import lsu_mem_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  load_type_t  load_type,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Halves only ever arrive on even offsets, so off[1] alone selects the half.
  assign byte_sel = rdata[{off, 3'b000} +: 8];
  assign half_sel = rdata[{off[1], 4'b0000} +: 16];

  always_comb begin
    data = rdata;
    case (load_type)
      LB:      data = {{24{byte_sel[7]}}, byte_sel};
      LBU:     data = {24'h000000, byte_sel};
      LH:      data = {{16{half_sel[15]}}, half_sel};
      LHU:     data = {16'h0000, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_access.sv
// Load/store unit: one outstanding request/grant bus access per instruction, stalling EX until done.
module lsu_mem_access
  import lsu_mem_access_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid_i,
  input  logic          mem_r_i,
  input  logic          mem_w_i,
  input  logic [2:0]    funct3_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic          stall_o,
  output logic          done_o,
  output logic [DW-1:0] load_data_o,
  output logic          misalign_o,
  output logic          bus_req_o,
  output logic          bus_we_o,
  output logic [AW-1:0] bus_addr_o,
  output logic [3:0]    bus_wstrb_o,
  output logic [DW-1:0] bus_wdata_o,
  input  logic          bus_gnt_i,
  input  logic          bus_rvalid_i,
  input  logic [DW-1:0] bus_rdata_i
);

  lsu_state_t    state_reg;
  logic          we_reg;
  logic [2:0]    f3_reg;
  logic [1:0]    off_reg;
  logic [AW-1:0] bus_addr_reg;
  logic [3:0]    wstrb_reg;
  logic [DW-1:0] wdata_reg;
  logic          misalign_reg;
  logic [DW-1:0] load_data_reg;

  logic          op;
  logic [3:0]    wstrb_next;
  logic [DW-1:0] wdata_next;
  logic [DW-1:0] aligned_data;

  // MemR together with MemW is treated as a store.
  assign op = ex_valid_i & (mem_r_i | mem_w_i);

  always_comb begin
    wstrb_next = 4'h0;
    wdata_next = wdata_i;
    if (mem_w_i) begin
      case (funct3_i)
        3'b000: begin
          wstrb_next = 4'b0001 << addr_i[1:0];
          wdata_next = {4{wdata_i[7:0]}};
        end
        3'b001: begin
          wstrb_next = 4'b0011 << addr_i[1:0];
          wdata_next = {2{wdata_i[15:0]}};
        end
        default: begin
          wstrb_next = 4'hF;
          wdata_next = wdata_i;
        end
      endcase
    end
  end

  lsu_mem_access_load_align u_load_align (
    .rdata     (bus_rdata_i),
    .off       (off_reg),
    .load_type (load_type_t'(f3_reg)),
    .data      (aligned_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      we_reg        <= 1'b0;
      f3_reg        <= 3'b000;
      off_reg       <= 2'b00;
      bus_addr_reg  <= '0;
      wstrb_reg     <= 4'h0;
      wdata_reg     <= '0;
      misalign_reg  <= 1'b0;
      load_data_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (op) begin
            we_reg       <= mem_w_i;
            f3_reg       <= funct3_i;
            off_reg      <= addr_i[1:0];
            bus_addr_reg <= {addr_i[AW-1:2], 2'b00};
            wstrb_reg    <= wstrb_next;
            wdata_reg    <= wdata_next;
            if (access_fault(mem_w_i, funct3_i, addr_i[1:0])) begin
              misalign_reg <= 1'b1;
              state_reg    <= DONE;
            end else begin
              misalign_reg <= 1'b0;
              state_reg    <= REQ;
            end
          end
        end
        REQ: begin
          if (bus_gnt_i) state_reg <= we_reg ? DONE : WAIT;
        end
        WAIT: begin
          if (bus_rvalid_i) begin
            load_data_reg <= aligned_data;
            state_reg     <= DONE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Stall is masked by reset so every output reads 0 while reset is held.
  assign stall_o     = ~rst & ((state_reg == IDLE & op) | state_reg == REQ | state_reg == WAIT);
  assign done_o      = (state_reg == DONE);
  assign misalign_o  = misalign_reg & done_o;
  assign load_data_o = load_data_reg;
  assign bus_req_o   = (state_reg == REQ);
  assign bus_we_o    = we_reg;
  assign bus_addr_o  = bus_addr_reg;
  assign bus_wstrb_o = wstrb_reg;
  assign bus_wdata_o = wdata_reg;

endmodule
